// File: rtl/uart_cfg_sequencer.sv
// ---------------------------------------------------------------------------
// uart_cfg_sequencer
//
// Boot-time configuration controller for a 16550 UART on an APB segment.
// After reset (and on request) it owns the downstream APB and issues the
// fixed initialisation write sequence:
//   LCR<-0x80 (DLAB=1), DLL<-DIVISOR[7:0], DLM<-DIVISOR[15:8],
//   LCR<-LCR_VAL, FCR<-FCR_VAL, IER<-IER_VAL
// It then becomes a transparent combinational pass-through between the
// upstream bridge (s_*) and the UART (m_*).
//
// Optional feature macro: UART_CFG_READBACK_EN
//   When defined, a read of LCR follows the last write. If the returned byte
//   differs from LCR_VAL, the sticky error flag is set.
//
// Ports:
//   clk, rst_n          clock (rising edge) / synchronous active-low reset
//   i_reinit            single-cycle request to rerun the sequence
//   o_cfg_done          high while the bus is in pass-through (registered)
//   o_cfg_err           sticky error flag, cleared when a sequence starts
//   s_psel .. s_pslverr upstream APB slave side (from the bridge)
//   m_psel .. m_pslverr downstream APB master side (to the UART)
// ---------------------------------------------------------------------------
module uart_cfg_sequencer #(
  parameter logic [15:0] DIVISOR = 16'd27,
  parameter logic [7:0]  LCR_VAL = 8'h03,
  parameter logic [7:0]  FCR_VAL = 8'hC7,
  parameter logic [7:0]  IER_VAL = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_reinit,
  output logic        o_cfg_done,
  output logic        o_cfg_err,
  // upstream APB (bridge side)
  input  logic        s_psel,
  input  logic        s_penable,
  input  logic        s_pwrite,
  input  logic [11:0] s_paddr,
  input  logic [31:0] s_pwdata,
  output logic [31:0] s_prdata,
  output logic        s_pready,
  output logic        s_pslverr,
  // downstream APB (UART side)
  output logic        m_psel,
  output logic        m_penable,
  output logic        m_pwrite,
  output logic [11:0] m_paddr,
  output logic [31:0] m_pwdata,
  input  logic [31:0] m_prdata,
  input  logic        m_pready,
  input  logic        m_pslverr
);

  // Register addresses are the 16550 register index shifted left by two.
  localparam logic [11:0] ADDR_DLL = 12'h000;
  localparam logic [11:0] ADDR_DLM = 12'h004;
  localparam logic [11:0] ADDR_IER = 12'h004;
  localparam logic [11:0] ADDR_FCR = 12'h008;
  localparam logic [11:0] ADDR_LCR = 12'h00C;

  localparam logic [7:0]  LCR_DLAB = 8'h80;
  localparam logic [2:0]  LAST_STEP = 3'd5;

`ifdef UART_CFG_READBACK_EN
  typedef enum logic [2:0] {
    ST_SETUP     = 3'd0,
    ST_ACCESS    = 3'd1,
    ST_DONE      = 3'd2,
    ST_WAIT_IDLE = 3'd3,
    ST_RB_SETUP  = 3'd4,
    ST_RB_ACCESS = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_SETUP     = 3'd0,
    ST_ACCESS    = 3'd1,
    ST_DONE      = 3'd2,
    ST_WAIT_IDLE = 3'd3
  } state_t;
`endif

  state_t     state_r;
  state_t     state_nxt_s;
  logic [2:0] step_r;
  logic [2:0] step_nxt_s;
  logic       cfg_done_r;
  logic       cfg_err_r;
  logic       err_nxt_s;

  // Downstream register address for each write step.
  function automatic logic [11:0] step_addr(input logic [2:0] step);
    case (step)
      3'd0:    step_addr = ADDR_LCR;
      3'd1:    step_addr = ADDR_DLL;
      3'd2:    step_addr = ADDR_DLM;
      3'd3:    step_addr = ADDR_LCR;
      3'd4:    step_addr = ADDR_FCR;
      3'd5:    step_addr = ADDR_IER;
      default: step_addr = 12'h000;
    endcase
  endfunction

  // Data byte written at each step.
  function automatic logic [7:0] step_data(input logic [2:0] step);
    case (step)
      3'd0:    step_data = LCR_DLAB;
      3'd1:    step_data = DIVISOR[7:0];
      3'd2:    step_data = DIVISOR[15:8];
      3'd3:    step_data = LCR_VAL;
      3'd4:    step_data = FCR_VAL;
      3'd5:    step_data = IER_VAL;
      default: step_data = 8'h00;
    endcase
  endfunction

  // State register, step counter and status flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= ST_SETUP;
      step_r     <= 3'd0;
      cfg_done_r <= 1'b0;
      cfg_err_r  <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      step_r     <= step_nxt_s;
      cfg_err_r  <= err_nxt_s;
      // done tracks the state being entered, so it stays high in WAIT_IDLE
      // and drops together with the move back into SETUP.
      cfg_done_r <= (state_nxt_s == ST_DONE) || (state_nxt_s == ST_WAIT_IDLE);
    end
  end

  // Next-state, step and error-flag logic.
  always_comb begin
    state_nxt_s = state_r;
    step_nxt_s  = step_r;
    err_nxt_s   = cfg_err_r;
    case (state_r)
      ST_SETUP: begin
        state_nxt_s = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (m_pready) begin
          // A slave error is recorded but the sequence carries on.
          if (m_pslverr) begin
            err_nxt_s = 1'b1;
          end else begin
            err_nxt_s = cfg_err_r;
          end
          if (step_r == LAST_STEP) begin
`ifdef UART_CFG_READBACK_EN
            state_nxt_s = ST_RB_SETUP;
`else
            state_nxt_s = ST_DONE;
`endif
          end else begin
            state_nxt_s = ST_SETUP;
            step_nxt_s  = step_r + 3'd1;
          end
        end else begin
          state_nxt_s = ST_ACCESS;
        end
      end
      ST_DONE: begin
        if (i_reinit) begin
          // An upstream transfer in flight must finish before we take the bus.
          if (s_psel) begin
            state_nxt_s = ST_WAIT_IDLE;
          end else begin
            state_nxt_s = ST_SETUP;
            step_nxt_s  = 3'd0;
            err_nxt_s   = 1'b0;
          end
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      ST_WAIT_IDLE: begin
        if (!s_psel) begin
          state_nxt_s = ST_SETUP;
          step_nxt_s  = 3'd0;
          err_nxt_s   = 1'b0;
        end else begin
          state_nxt_s = ST_WAIT_IDLE;
        end
      end
`ifdef UART_CFG_READBACK_EN
      ST_RB_SETUP: begin
        state_nxt_s = ST_RB_ACCESS;
      end
      ST_RB_ACCESS: begin
        if (m_pready) begin
          if (m_pslverr || (m_prdata[7:0] != LCR_VAL)) begin
            err_nxt_s = 1'b1;
          end else begin
            err_nxt_s = cfg_err_r;
          end
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_RB_ACCESS;
        end
      end
`endif
      default: begin
        state_nxt_s = ST_SETUP;
        step_nxt_s  = 3'd0;
      end
    endcase
  end

  // Bus multiplexing: sequencer drive, pass-through, or idle during reset.
  always_comb begin
    m_psel    = 1'b0;
    m_penable = 1'b0;
    m_pwrite  = 1'b0;
    m_paddr   = 12'h000;
    m_pwdata  = 32'h0000_0000;
    s_prdata  = 32'h0000_0000;
    s_pready  = 1'b0;
    s_pslverr = 1'b0;
    // The state register already reads SETUP while rst_n is low, so the
    // bus is explicitly held idle until reset is released.
    if (!rst_n) begin
      m_psel = 1'b0;
    end else begin
      case (state_r)
        ST_SETUP: begin
          m_psel   = 1'b1;
          m_pwrite = 1'b1;
          m_paddr  = step_addr(step_r);
          m_pwdata = {24'h00_0000, step_data(step_r)};
        end
        ST_ACCESS: begin
          m_psel    = 1'b1;
          m_penable = 1'b1;
          m_pwrite  = 1'b1;
          m_paddr   = step_addr(step_r);
          m_pwdata  = {24'h00_0000, step_data(step_r)};
        end
        ST_DONE, ST_WAIT_IDLE: begin
          m_psel    = s_psel;
          m_penable = s_penable;
          m_pwrite  = s_pwrite;
          m_paddr   = s_paddr;
          m_pwdata  = s_pwdata;
          s_prdata  = m_prdata;
          s_pready  = m_pready;
          s_pslverr = m_pslverr;
        end
`ifdef UART_CFG_READBACK_EN
        ST_RB_SETUP: begin
          m_psel  = 1'b1;
          m_paddr = ADDR_LCR;
        end
        ST_RB_ACCESS: begin
          m_psel    = 1'b1;
          m_penable = 1'b1;
          m_paddr   = ADDR_LCR;
        end
`endif
        default: begin
          m_psel = 1'b0;
        end
      endcase
    end
  end

  assign o_cfg_done = cfg_done_r;
  assign o_cfg_err  = cfg_err_r;

endmodule

// File: doc/uart_cfg_sequencer.md
# uart_cfg_sequencer

Boot-time configuration controller for the 16550 UART behind the AXI-to-APB bridge. It sits on the APB segment between the bridge (upstream) and the UART (downstream). After reset, and on request, it owns the downstream APB and issues the fixed 16550 initialisation write sequence. It then hands the bus back to the bridge as a transparent pass-through.

## Interface
Parameters:
- DIVISOR, 16'd27, baud divisor written to DLL/DLM (50 MHz / (16 × 115200)).
- LCR_VAL, 8'h03, final line control value (8N1, DLAB=0).
- FCR_VAL, 8'hC7, FIFO control value (enable, clear both FIFOs, 14-byte trigger).
- IER_VAL, 8'h00, interrupt enable value.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- i_reinit  in  1  single-cycle request to rerun the sequence.
- o_cfg_done  out  1  high while the bus is in pass-through.
- o_cfg_err  out  1  sticky error flag; cleared when a sequence starts.
- s_psel, s_penable, s_pwrite  in  1 each  upstream APB control from the bridge.
- s_paddr  in  12  upstream address.
- s_pwdata  in  32  upstream write data.
- s_prdata  out  32  upstream read data.
- s_pready  out  1  upstream ready.
- s_pslverr  out  1  upstream error.
- m_psel, m_penable, m_pwrite  out  1 each  downstream APB control to the UART.
- m_paddr  out  12  downstream address.
- m_pwdata  out  32  downstream write data.
- m_prdata  in  32  downstream read data (UART byte in bits [7:0]).
- m_pready, m_pslverr  in  1 each  downstream ready and error.

## Operation
- Register address = index << 2.
- Write sequence, steps 0..5, data in m_pwdata[7:0] with upper bits zero:
  - step 0: LCR 0x00C ← 8'h80
  - step 1: DLL 0x000 ← DIVISOR[7:0]
  - step 2: DLM 0x004 ← DIVISOR[15:8]
  - step 3: LCR 0x00C ← LCR_VAL
  - step 4: FCR 0x008 ← FCR_VAL
  - step 5: IER 0x004 ← IER_VAL
- States:
  - SETUP: m_psel=1, m_penable=0. Always goes to ACCESS the next cycle.
  - ACCESS: m_psel=1, m_penable=1. Held until m_pready=1. Then go to SETUP with step+1, or to DONE after step 5 (to RB_SETUP when readback is compiled in).
  - DONE: pass-through.
  - WAIT_IDLE: reinit pending.
- m_pslverr=1 on any completing ACCESS sets o_cfg_err. The sequence continues regardless.
- The 3-bit step counter never exceeds 5. There is no wrap.
- DONE pass-through, all combinational:
  - m_psel, m_penable, m_pwrite, m_paddr, m_pwdata = the matching s_* signals.
  - s_prdata = m_prdata; s_pready = m_pready; s_pslverr = m_pslverr.
- Outside DONE (sequencer owns the bus):
  - s_pready=0, s_prdata=0, s_pslverr=0. The upstream transfer stalls and is never forwarded.
  - m_pwrite=1 during write steps.
- Reinit:
  - i_reinit in DONE with s_psel=0: go to SETUP, step 0, the next cycle.
  - i_reinit in DONE with s_psel=1: go to WAIT_IDLE (pass-through continues). Leave WAIT_IDLE for SETUP on the first cycle with s_psel=0.
  - i_reinit outside DONE/WAIT_IDLE is ignored and not queued.
  - o_cfg_err clears on the cycle a sequence enters SETUP at step 0.

## Timing
- Reset values of registered outputs and state:
  - o_cfg_done=0, o_cfg_err=0, step=0, state=SETUP.
  - Combinational outputs during reset: m_psel=0, m_penable=0, m_pwrite=0, m_paddr=0, m_pwdata=0, s_pready=0, s_prdata=0, s_pslverr=0.
- First cycle after rst_n rises: SETUP of step 0 is driven.
- Each write takes 2 cycles minimum (1 SETUP + ≥1 ACCESS). With m_pready=1 on first ACCESS, full write sequence = 12 cycles.
- o_cfg_done rises the cycle after the last ACCESS completes. It falls the cycle after leaving DONE/WAIT_IDLE, i.e. it stays high in WAIT_IDLE.
- Reset asserted mid-sequence or mid-pass-through: everything returns to reset values on that edge. The sequence restarts from step 0 with no partial-step resume.
- Simultaneous i_reinit and a completing upstream transfer (s_psel=1, s_pready=1): take the WAIT_IDLE path.

## Configuration
- UART_CFG_READBACK_EN:
  - Defined: after step 5, add a read of LCR (0x00C, m_pwrite=0) through RB_SETUP/RB_ACCESS. On completion, m_prdata[7:0] != LCR_VAL sets o_cfg_err, then go to DONE. The sequence is 14 cycles minimum.
  - Undefined: RB states and the comparator are absent; step 5 goes straight to DONE.

## Test plan
- Reset release with m_pready tied 1, default parameters:
  - exactly six writes (0x00C/80, 0x000/1B, 0x004/00, 0x00C/03, 0x008/C7, 0x004/00);
  - o_cfg_done=1 at cycle 13 after reset release;
  - o_cfg_err=0.
- m_pready low for 3 cycles on step 2 ACCESS: m_paddr/m_pwdata stable through the stall; done is delayed by exactly 3 cycles.
- Upstream read of 0x014 issued during sequencing: s_pready=0 until done; then forwarded and completes with s_prdata = m_prdata.
- i_reinit while s_psel=1 in DONE:
  - pass-through continues;
  - the sequence starts the cycle after s_psel falls;
  - o_cfg_done falls then.
- m_pslverr=1 on step 4: o_cfg_err=1 and remains set after done; the next i_reinit clears it.
- With UART_CFG_READBACK_EN and m_prdata=8'h83 on readback: o_cfg_err=1 and o_cfg_done=1. Mid-sequence rst_n low for 1 cycle: restart at step 0 with LCR←8'h80.
